axi4_refill_req_issuer: RTL
===========================

Name: axi4_refill_req_issuer

Overview:
Upstream neighbour of the refill response deserializer in the L1.5 instruction cache. Accepts cache-line refill and bypass fetch requests from the cache controller and issues AXI4 AR transactions.
- Refills become INCR bursts sized to one full cache line; bypass fetches become single beats.
- Tracks outstanding bursts by snooping R-channel last-beat handshakes and throttles new requests at a credit limit.

Parameters:
CACHE_LINE, 4, ICACHE_DATA_WIDTH words per line
ICACHE_DATA_WIDTH, 32, bits per cache word
AXI_ADDR, 32, AXI address width
AXI_ID, 6, AXI ID width
AXI_DATA, 64, AXI data width (power of 2, >=8)
AXI_USER, 8, AXI user width
MAX_OUTSTANDING, 4, max in-flight AR bursts (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
refill_req_i  in  1  request valid
refill_addr_i  in  AXI_ADDR  fetch byte address
refill_id_i  in  AXI_ID  transaction ID
refill_user_i  in  AXI_USER  user sideband
refill_bypass_i  in  1  1 = single-beat bypass fetch
refill_gnt_o  out  1  request accepted this cycle
init_arid_o/araddr_o/arlen_o/arsize_o/arburst_o  out  AXI_ID/AXI_ADDR/8/3/2  AR fields
init_arlock_o/arcache_o/arprot_o/arregion_o/arqos_o/aruser_o  out  1/4/3/4/4/AXI_USER  AR fields
init_arvalid_o  out  1  AR valid
init_arready_i  in  1  AR ready
init_rvalid_i, init_rready_i, init_rlast_i  in  1 each  R-channel snoop (never driven)
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight burst count
idle_o  out  1  state IDLE and outstanding == 0

Behaviour:
Derived constants:
- BEATS = CACHE_LINE*ICACHE_DATA_WIDTH/AXI_DATA. It must be an integer >=1; elaboration error otherwise.
- LINE_BYTES = CACHE_LINE*ICACHE_DATA_WIDTH/8.
- BUS_BYTES = AXI_DATA/8.

Reset: arvalid 0, all AR field registers 0, outstanding 0, state IDLE. The reset is asynchronous and active-low; one clock.

FSM has two states, IDLE and ISSUE.
- IDLE: refill_gnt_o = (outstanding_q < MAX_OUTSTANDING). On req & gnt, register the AR fields and go to ISSUE. init_arvalid_o rises the next cycle (one-cycle latency).
- ISSUE: init_arvalid_o = 1. All AR outputs are held stable until init_arready_i.
  - refill_gnt_o = init_arready_i & (outstanding_q + 1 < MAX_OUTSTANDING). This is a combinational path from arready.
  - On arready with req & gnt: reload the fields and stay in ISSUE, giving back-to-back AR with zero bubble.
  - On arready without an accepted request: go to IDLE.

AR encoding:
- Refill: araddr = addr & ~(LINE_BYTES-1), arlen = BEATS-1.
- Bypass: araddr = addr & ~(BUS_BYTES-1), arlen = 0.
- Both: arsize = log2(BUS_BYTES), arburst = 2'b01 (INCR), arlock 0, arcache 4'b0010, arprot 3'b100, arregion 0, arqos 0. arid and aruser are taken from the request.

Credit counter:
- +1 on AR handshake (arvalid & arready).
- -1 on R last handshake (rvalid & rready & rlast).
- Both in the same cycle: unchanged.
- Decrement at 0: ignored; the counter saturates at 0.
- Released credit becomes visible to refill_gnt_o the next cycle; it never frees credit combinationally.
- Overflow is impossible by construction of the grant.

Reset mid-operation clears the FSM and counter immediately. In-flight AXI state is lost, and the system resets the interconnect together with this block.

Optional Feature:
Macro REFILL_PERF_CNT_EN.
- Defined: adds ports perf_clr_i (in, 1), perf_ar_cnt_o (out, 32) and perf_stall_cnt_o (out, 32).
  - perf_ar_cnt_o counts AR handshakes.
  - perf_stall_cnt_o counts cycles with arvalid & !arready.
  - Both counters wrap at 2^32, reset to 0, and clear synchronously on perf_clr_i; clear has priority over increment.
- Undefined: the ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- Package refill_axi_pkg:
  - AXI constants: BURST_INCR, the resp codes OKAY/EXOKAY/SLVERR/DECERR, ARCACHE_DEFAULT, ARPROT_INSTR.
  - Function axi_size(bytes) returning the arsize encoding.
  - Enum for the IDLE/ISSUE state.
- Sub-module refill_credit_counter holds the saturating up/down counter, parameterised by MAX_OUTSTANDING. It is reusable by the response side.

Test Plan:
- Reset, then idle with no request -> arvalid 0, outstanding_o 0, refill_gnt_o 1, idle_o 1.
- Refill request addr 0x1000_0014, arready tied 1 (defaults) -> next cycle araddr 0x1000_0010, arlen 1, arsize 3, arburst 01, arprot 100, one-cycle arvalid pulse, outstanding_o 1.
- Bypass request addr 0x1000_0014 -> araddr 0x1000_0010, arlen 0. Bypass addr 0x1000_001C -> araddr 0x1000_0018.
- 4 refills with no R last beats -> 4th AR issued, 5th request sees refill_gnt_o 0. One rvalid&rready&rlast -> refill_gnt_o 1 on the following cycle.
- Hold arready 0 for 5 cycles while a new request is pending -> AR fields stable and refill_gnt_o 0 throughout; with REFILL_PERF_CNT_EN, perf_stall_cnt_o reads 5.
- AR handshake and rlast handshake in the same cycle at outstanding 2 -> outstanding stays 2. rlast at outstanding 0 -> stays 0.

Source files
------------

// File: rtl/refill_axi_pkg.sv
// AXI4 encodings, AR-issuer state type and arsize helper shared by the refill request/response blocks.
package refill_axi_pkg;

  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_EXOKAY     = 2'b01;
  localparam logic [1:0] RESP_SLVERR     = 2'b10;
  localparam logic [1:0] RESP_DECERR     = 2'b11;
  localparam logic [3:0] ARCACHE_DEFAULT = 4'b0010;
  localparam logic [2:0] ARPROT_INSTR    = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

  // arsize encoding is log2 of the beat width in bytes
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    logic [2:0] sz;
    sz = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/refill_credit_counter.sv
// Saturating up/down count of in-flight bursts; updates one cycle after inc/dec.
// No backpressure: simultaneous inc and dec cancel, dec at zero is dropped.
module refill_credit_counter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && count != MAX_CNT) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi4_refill_req_issuer.sv
// Turns refill/bypass fetch requests into AXI4 AR bursts; AR appears one cycle after grant, back-to-back under arready.
// Grant is withheld while AR stalls or credits run out. Optional perf counters under REFILL_PERF_CNT_EN.
module axi4_refill_req_issuer
  import refill_axi_pkg::*;
#(
  parameter int CACHE_LINE        = 4,
  parameter int ICACHE_DATA_WIDTH = 32,
  parameter int AXI_ADDR          = 32,
  parameter int AXI_ID            = 6,
  parameter int AXI_DATA          = 64,
  parameter int AXI_USER          = 8,
  parameter int MAX_OUTSTANDING   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          refill_req_i,
  input  logic [AXI_ADDR-1:0]           refill_addr_i,
  input  logic [AXI_ID-1:0]             refill_id_i,
  input  logic [AXI_USER-1:0]           refill_user_i,
  input  logic                          refill_bypass_i,
  output logic                          refill_gnt_o,
  output logic [AXI_ID-1:0]             init_arid_o,
  output logic [AXI_ADDR-1:0]           init_araddr_o,
  output logic [7:0]                    init_arlen_o,
  output logic [2:0]                    init_arsize_o,
  output logic [1:0]                    init_arburst_o,
  output logic                          init_arlock_o,
  output logic [3:0]                    init_arcache_o,
  output logic [2:0]                    init_arprot_o,
  output logic [3:0]                    init_arregion_o,
  output logic [3:0]                    init_arqos_o,
  output logic [AXI_USER-1:0]           init_aruser_o,
  output logic                          init_arvalid_o,
  input  logic                          init_arready_i,
  input  logic                          init_rvalid_i,
  input  logic                          init_rready_i,
  input  logic                          init_rlast_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                          idle_o
`ifdef REFILL_PERF_CNT_EN
  ,
  input  logic                          perf_clr_i,
  output logic [31:0]                   perf_ar_cnt_o,
  output logic [31:0]                   perf_stall_cnt_o
`endif
);

  localparam int BEATS      = CACHE_LINE * ICACHE_DATA_WIDTH / AXI_DATA;
  localparam int LINE_BYTES = CACHE_LINE * ICACHE_DATA_WIDTH / 8;
  localparam int BUS_BYTES  = AXI_DATA / 8;
  localparam int CW         = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [AXI_ADDR-1:0] LINE_MASK = AXI_ADDR'(LINE_BYTES - 1);
  localparam logic [AXI_ADDR-1:0] BUS_MASK  = AXI_ADDR'(BUS_BYTES - 1);
  localparam logic [CW:0]         MAX_CNT   = (CW + 1)'(MAX_OUTSTANDING);

  if (BEATS < 1 || BEATS * AXI_DATA != CACHE_LINE * ICACHE_DATA_WIDTH) begin : g_bad_beats
    $error("cache line must be a whole number (>=1) of AXI data beats");
  end

  typedef struct packed {
    logic [AXI_ID-1:0]   id;
    logic [AXI_ADDR-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          region;
    logic [3:0]          qos;
    logic [AXI_USER-1:0] user;
  } ar_hdr_t;

  issue_state_e state_q, state_d;
  ar_hdr_t      ar_q, ar_d;
  logic [CW-1:0] out_q;
  logic [CW:0]   out_ext;
  logic          load, ar_hs, r_last_hs;

  assign out_ext   = {1'b0, out_q};
  assign ar_hs     = init_arvalid_o & init_arready_i;
  assign r_last_hs = init_rvalid_i & init_rready_i & init_rlast_i;
  assign load      = refill_req_i & refill_gnt_o;

  // In ISSUE a new grant needs room for the burst that is handshaking right now
  always_comb begin
    state_d      = state_q;
    refill_gnt_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        refill_gnt_o = (out_ext < MAX_CNT);
        if (load) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        refill_gnt_o = init_arready_i & ((out_ext + 1'b1) < MAX_CNT);
        if (init_arready_i && !load) state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ar_d = ar_q;
    if (load) begin
      ar_d.id     = refill_id_i;
      ar_d.user   = refill_user_i;
      ar_d.addr   = refill_bypass_i ? (refill_addr_i & ~BUS_MASK) : (refill_addr_i & ~LINE_MASK);
      ar_d.len    = refill_bypass_i ? 8'd0 : 8'(BEATS - 1);
      ar_d.size   = axi_size(BUS_BYTES);
      ar_d.burst  = BURST_INCR;
      ar_d.lock   = 1'b0;
      ar_d.cache  = ARCACHE_DEFAULT;
      ar_d.prot   = ARPROT_INSTR;
      ar_d.region = 4'd0;
      ar_d.qos    = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
    end
  end

  refill_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CW             (CW)
  ) u_credit (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (ar_hs),
    .dec  (r_last_hs),
    .count(out_q)
  );

  assign init_arvalid_o  = (state_q == ST_ISSUE);
  assign init_arid_o     = ar_q.id;
  assign init_araddr_o   = ar_q.addr;
  assign init_arlen_o    = ar_q.len;
  assign init_arsize_o   = ar_q.size;
  assign init_arburst_o  = ar_q.burst;
  assign init_arlock_o   = ar_q.lock;
  assign init_arcache_o  = ar_q.cache;
  assign init_arprot_o   = ar_q.prot;
  assign init_arregion_o = ar_q.region;
  assign init_arqos_o    = ar_q.qos;
  assign init_aruser_o   = ar_q.user;
  assign outstanding_o   = out_q;
  assign idle_o          = (state_q == ST_IDLE) && (out_q == '0);

`ifdef REFILL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ar_cnt_o    <= '0;
      perf_stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      perf_ar_cnt_o    <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (ar_hs) perf_ar_cnt_o <= perf_ar_cnt_o + 32'd1;
      if (init_arvalid_o && !init_arready_i) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
